mips32_pipe_fwd: RTL and testbench
==================================

// Module: mips32_pipe_fwd
// PURPOSE
// - Single-clock, parametrised 5-stage in-order core (IF/ID/EX/MEM/WB); next generation of the MIPS32 pipeline.
// - Same 32-bit ISA: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
// - Adds full forwarding, load-use interlock, branch flush, reset and external memory ports.
// - Sits as the CPU core; the top level owns instruction/data memories and the halt/debug observers.
// PARAMETERS
// XLEN      32  datapath/register width; must be >= 16
// NREG      32  architectural registers; R0 reads 0; rs/rt/rd index mod NREG
// IMEM_AW   10  instruction word-address width = PC width
// DMEM_AW   10  data word-address width
// RESET_PC  0   PC value loaded at reset
// PORTS
// clk         in   1        single clock, all flops on rising edge
// rst         in   1        asynchronous, active-high reset
// imem_addr   out  IMEM_AW  fetch address (= PC)
// imem_rdata  in   32       instruction at imem_addr, combinational same cycle
// dmem_addr   out  DMEM_AW  MEM-stage address (ALU result, low bits)
// dmem_wdata  out  XLEN     store data
// dmem_we     out  1        store strobe, one cycle per SW
// dmem_rdata  in   XLEN     load data at dmem_addr, combinational same cycle
// halted      out  1        sticky; HLT or illegal op retired
// illegal_op  out  1        sticky; the halting instruction had an undefined opcode
// retire_cnt  out  32       instructions retired in WB, bubbles excluded, wraps
// BEHAVIOUR
// - Reset: PC=RESET_PC, all stage valid bits=0, regs=0, dmem_we=0, halted=0, illegal_op=0, retire_cnt=0.
// - Reset is honoured mid-pipeline: in-flight instructions are discarded and no store is issued.
// - Opcodes: ADD 00 SUB 01 AND 02 OR 03 SLT 04 MUL 05 LW 08 SW 09 ADDI 0A SUBI 0B SLTI 0C BNEQZ 0D BEQZ 0E HLT 3F.
//   Any other opcode behaves as HLT and sets illegal_op.
// - Arithmetic: modulo 2^XLEN; MUL keeps the low XLEN bits; SLT/SLTI compare signed and return 0/1.
//   imm is sign-extended to XLEN.
// - Writeback: RR ops write rd, RM ops and LW write rt, in WB; writes to R0 are dropped.
//   The regfile is write-before-read, so a WB write is visible to ID in the same cycle.
// - Forwarding to EX operands, priority EX/MEM over MEM/WB.
//   Sources: ALU results only; LW data comes only from MEM/WB.
// - Load-use: if ID needs the rt/rs written by an LW in EX, hold PC and IF/ID one cycle and insert an EX bubble.
//   Penalty is exactly 1 cycle.
// - Branch: resolved in EX. BEQZ is taken if fwd(rs)==0, BNEQZ if !=0; target = NPC+imm, mod 2^IMEM_AW.
//   Taken: PC<=target and IF/ID and ID/EX are flushed; 2 bubbles, no side effects from flushed slots.
//   Not-taken: no penalty.
// - Store: dmem_we=1 for exactly the MEM cycle of a valid SW; flushed or bubble slots never write.
// - Halt: HLT decoded in ID freezes fetch; older instructions drain normally.
//   halted rises the cycle HLT is in WB; after that the pipeline and retire_cnt are frozen until rst.
// - Simultaneous taken branch in EX and load-use stall in ID: flush wins, no stall cycle.
// - A branch that is a forwarding target of an older ALU op uses the forwarded value.
// STRUCTURE
// - Package mips32_pkg: opcode localparams, instruction-type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT),
//   field-slice functions.
// - Sub-module mips32_regfile: NREG x XLEN, 2 async read ports, 1 write port, internal bypass, R0 = 0, async reset.
// - Hazard/forward logic and stage registers stay in this module.
// TESTING
// 1. ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; HLT -> R3=30, no stalls, halted@cycle 8, retire_cnt=4.
// 2. LW R1,0(R0) with mem[0]=0x55; ADD R2,R1,R1 -> exactly 1 stall cycle, R2=0xAA.
// 3. ADDI R1,R0,3; loop: SUBI R1,R1,1; BNEQZ R1,loop -> 3 iterations, R1=0, each taken branch costs 2 bubbles.
// 4. SW after taken BEQZ in delay slots: mem[5] pre=7, flushed SW R2,5(R0) -> mem[5] stays 7, dmem_we never high.
// 5. Opcode 0x20 at PC 2 -> illegal_op=1, halted=1, instructions at PC 0,1 retired, retire_cnt=3.
// 6. Assert rst while an LW and SW are in flight -> outputs at reset values next edge, no dmem_we, restart at RESET_PC.

Source files
------------

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared definitions for the forwarding 5-stage MIPS32 core.
// Holds the opcode map, the instruction-class enum that steers each pipeline
// stage, and helpers that slice instruction fields and classify opcodes.
package mips32_pkg;

   localparam logic [5:0] OP_ADD   = 6'h00;
   localparam logic [5:0] OP_SUB   = 6'h01;
   localparam logic [5:0] OP_AND   = 6'h02;
   localparam logic [5:0] OP_OR    = 6'h03;
   localparam logic [5:0] OP_SLT   = 6'h04;
   localparam logic [5:0] OP_MUL   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h08;
   localparam logic [5:0] OP_SW    = 6'h09;
   localparam logic [5:0] OP_ADDI  = 6'h0A;
   localparam logic [5:0] OP_SUBI  = 6'h0B;
   localparam logic [5:0] OP_SLTI  = 6'h0C;
   localparam logic [5:0] OP_BNEQZ = 6'h0D;
   localparam logic [5:0] OP_BEQZ  = 6'h0E;
   localparam logic [5:0] OP_HLT   = 6'h3F;

   typedef enum logic [2:0] {
      RR_ALU,
      RM_ALU,
      LOAD,
      STORE,
      BRANCH,
      HALT
   } itype_t;

   function automatic logic [5:0] f_opcode(input logic [31:0] ir);
      return ir[31:26];
   endfunction

   function automatic logic [4:0] f_rs(input logic [31:0] ir);
      return ir[25:21];
   endfunction

   function automatic logic [4:0] f_rt(input logic [31:0] ir);
      return ir[20:16];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] ir);
      return ir[15:11];
   endfunction

   function automatic logic [15:0] f_imm(input logic [31:0] ir);
      return ir[15:0];
   endfunction

   // Undefined opcodes fall into HALT so they stop the core like HLT does.
   function automatic itype_t decode_itype(input logic [5:0] op);
      itype_t t;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: t = RR_ALU;
         OP_ADDI, OP_SUBI, OP_SLTI:                     t = RM_ALU;
         OP_LW:                                         t = LOAD;
         OP_SW:                                         t = STORE;
         OP_BNEQZ, OP_BEQZ:                             t = BRANCH;
         default:                                       t = HALT;
      endcase
      return t;
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
         OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI,
         OP_BNEQZ, OP_BEQZ, OP_HLT: ok = 1'b1;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips32_regfile.sv
// mips32_regfile: NREG x XLEN architectural register file.
// Ports: clk, rst (async, active-high, clears every register);
//        ra1/rd1, ra2/rd2 combinational read ports;
//        we/wa/wd single write port committed on the rising edge.
// R0 always reads zero and ignores writes. A write in the same cycle as a
// read of the same register is bypassed so ID sees the WB result at once.
module mips32_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RAW-1:0]  ra1,
   input  logic [RAW-1:0]  ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [RAW-1:0]  wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
   assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : regs[ra2]);

endmodule

// File: rtl/mips32_pipe_fwd.sv
// mips32_pipe_fwd: 5-stage in-order MIPS32 core (IF/ID/EX/MEM/WB) with full
// forwarding, load-use interlock, EX-resolved branches and halt handling.
// Ports:
//   clk, rst         single rising-edge clock; async active-high reset
//   imem_addr/rdata  fetch address (= PC) and same-cycle instruction word
//   dmem_addr/wdata  MEM-stage address and store data
//   dmem_we          store strobe, one cycle per valid SW in MEM
//   dmem_rdata       same-cycle load data at dmem_addr
//   halted           sticky, high from the cycle HLT/illegal op is in WB
//   illegal_op       sticky, the halting instruction was undefined
//   retire_cnt       instructions retired in WB (bubbles excluded), wraps
module mips32_pipe_fwd #(
   parameter int                 XLEN     = 32,
   parameter int                 NREG     = 32,
   parameter int                 IMEM_AW  = 10,
   parameter int                 DMEM_AW  = 10,
   parameter logic [IMEM_AW-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [XLEN-1:0]    dmem_wdata,
   output logic               dmem_we,
   input  logic [XLEN-1:0]    dmem_rdata,
   output logic               halted,
   output logic               illegal_op,
   output logic [31:0]        retire_cnt
);

   import mips32_pkg::*;

   localparam int RAW = (NREG > 1) ? $clog2(NREG) : 1;

   // Register fields index modulo NREG.
   function automatic logic [RAW-1:0] ridx(input logic [4:0] f);
      return RAW'(32'(f) % 32'(NREG));
   endfunction

   function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
      logic signed [15:0] s;
      s = v;
      return XLEN'(s);
   endfunction

   // Shared by RR, RM, and address generation (LW/SW use the add path).
   function automatic logic [XLEN-1:0] alu(input logic [5:0]      op,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      logic [XLEN-1:0]        r;
      sa = a;
      sb = b;
      case (op)
         OP_SUB, OP_SUBI: r = a - b;
         OP_AND:          r = a & b;
         OP_OR:           r = a | b;
         OP_SLT, OP_SLTI: r = (sa < sb) ? XLEN'(1) : '0;
         OP_MUL:          r = a * b;
         default:         r = a + b;
      endcase
      return r;
   endfunction

   // Control state (reset)
   logic [IMEM_AW-1:0] pc;
   logic               fetch_stop;
   logic               vld_p1, vld_p2, vld_p3, vld_p4;
   logic               halted_r, illegal_r;

   // Datapath state (no reset; qualified by the valid bits)
   logic [31:0]        ir_p1;
   logic [IMEM_AW-1:0] npc_p1, npc_p2;
   itype_t             it_p2, it_p3, it_p4;
   logic [5:0]         op_p2;
   logic [RAW-1:0]     rs_p2, rt_p2, dst_p2, dst_p3, dst_p4;
   logic               wen_p2, wen_p3, wen_p4;
   logic               illegal_p2, illegal_p3, illegal_p4;
   logic [XLEN-1:0]    a_p2, b_p2, imm_p2;
   logic [XLEN-1:0]    alu_p3, b_p3, alu_p4, lmd_p4;

   // ID decode
   logic [5:0]         op_id;
   itype_t             it_id;
   logic [RAW-1:0]     rs_id, rt_id, rd_id, dst_id;
   logic               wen_id, need_rs_id, need_rt_id, illegal_id;
   logic [XLEN-1:0]    rs_val_id, rt_val_id, imm_id;

   // Hazard / EX
   logic               halt_id, freeze_fetch, stall, br_taken, run;
   logic [IMEM_AW-1:0] pc_inc, br_target;
   logic [XLEN-1:0]    fa, fb, alu_ex, wb_val;
   logic               ex_fwd_ok, wb_fwd_ok, wb_we;

   assign run       = !halted_r;
   assign pc_inc    = pc + IMEM_AW'(1);
   assign imem_addr = pc;

   // ---- IF/ID boundary: decode ----
   always_comb begin
      op_id      = f_opcode(ir_p1);
      it_id      = decode_itype(op_id);
      illegal_id = !is_legal(op_id);
      rs_id      = ridx(f_rs(ir_p1));
      rt_id      = ridx(f_rt(ir_p1));
      rd_id      = ridx(f_rd(ir_p1));
      imm_id     = sext16(f_imm(ir_p1));
      dst_id     = (it_id == RR_ALU) ? rd_id : rt_id;
      wen_id     = it_id inside {RR_ALU, RM_ALU, LOAD};
      need_rs_id = it_id inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
      need_rt_id = it_id inside {RR_ALU, STORE};
   end

   mips32_regfile #(
      .XLEN (XLEN),
      .NREG (NREG),
      .RAW  (RAW)
   ) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs_id),
      .ra2 (rt_id),
      .rd1 (rs_val_id),
      .rd2 (rt_val_id),
      .we  (wb_we),
      .wa  (dst_p4),
      .wd  (wb_val)
   );

   // A load in EX cannot forward yet; hold the consumer in ID one cycle.
   assign stall = vld_p1 && vld_p2 && (it_p2 == LOAD) && (dst_p2 != '0) &&
                  ((need_rs_id && (rs_id == dst_p2)) ||
                   (need_rt_id && (rt_id == dst_p2)));

   assign halt_id      = vld_p1 && (it_id == HALT);
   assign freeze_fetch = fetch_stop || halt_id;

   // ---- ID/EX boundary: forwarding, ALU, branch resolution ----
   assign ex_fwd_ok = vld_p3 && wen_p3 && (it_p3 != LOAD) && (dst_p3 != '0);
   assign wb_fwd_ok = vld_p4 && wen_p4 && (dst_p4 != '0);
   assign wb_val    = (it_p4 == LOAD) ? lmd_p4 : alu_p4;

   always_comb begin
      fa = a_p2;
      fb = b_p2;
      if (ex_fwd_ok && (dst_p3 == rs_p2))      fa = alu_p3;
      else if (wb_fwd_ok && (dst_p4 == rs_p2)) fa = wb_val;
      if (ex_fwd_ok && (dst_p3 == rt_p2))      fb = alu_p3;
      else if (wb_fwd_ok && (dst_p4 == rt_p2)) fb = wb_val;
   end

   assign alu_ex    = alu(op_p2, fa, (it_p2 == RR_ALU) ? fb : imm_p2);
   assign br_target = npc_p2 + imm_p2[IMEM_AW-1:0];
   // BEQZ takes on zero, BNEQZ on non-zero.
   assign br_taken  = vld_p2 && (it_p2 == BRANCH) &&
                      ((op_p2 == OP_BEQZ) == (fa == '0));

   // ---- EX/MEM boundary: data memory ----
   assign dmem_addr  = alu_p3[DMEM_AW-1:0];
   assign dmem_wdata = b_p3;
   assign dmem_we    = run && vld_p3 && (it_p3 == STORE);

   // ---- MEM/WB boundary: writeback and retirement ----
   assign wb_we      = run && vld_p4 && wen_p4;
   assign halted     = halted_r || (vld_p4 && (it_p4 == HALT));
   assign illegal_op = illegal_r || (vld_p4 && (it_p4 == HALT) && illegal_p4);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         fetch_stop <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         vld_p3     <= 1'b0;
         vld_p4     <= 1'b0;
         halted_r   <= 1'b0;
         illegal_r  <= 1'b0;
         retire_cnt <= '0;
      end else if (run) begin
         // A taken branch overrides both the stall and a halt sitting in ID.
         if (br_taken)                    pc <= br_target;
         else if (!stall && !freeze_fetch) pc <= pc_inc;

         if (halt_id && !br_taken) fetch_stop <= 1'b1;

         if (br_taken)    vld_p1 <= 1'b0;
         else if (!stall) vld_p1 <= !freeze_fetch;

         vld_p2 <= vld_p1 && !br_taken && !stall;
         vld_p3 <= vld_p2;
         vld_p4 <= vld_p3;

         if (vld_p4) begin
            retire_cnt <= retire_cnt + 32'd1;
            if (it_p4 == HALT) begin
               halted_r  <= 1'b1;
               illegal_r <= illegal_p4;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (run) begin
         if (!br_taken && !stall && !freeze_fetch) begin
            ir_p1  <= imem_rdata;
            npc_p1 <= pc_inc;
         end

         it_p2      <= it_id;
         op_p2      <= op_id;
         rs_p2      <= rs_id;
         rt_p2      <= rt_id;
         dst_p2     <= dst_id;
         wen_p2     <= wen_id;
         illegal_p2 <= illegal_id;
         a_p2       <= rs_val_id;
         b_p2       <= rt_val_id;
         imm_p2     <= imm_id;
         npc_p2     <= npc_p1;

         it_p3      <= it_p2;
         dst_p3     <= dst_p2;
         wen_p3     <= wen_p2;
         illegal_p3 <= illegal_p2;
         alu_p3     <= alu_ex;
         b_p3       <= fb;

         it_p4      <= it_p3;
         dst_p4     <= dst_p3;
         wen_p4     <= wen_p3;
         illegal_p4 <= illegal_p3;
         alu_p4     <= alu_p3;
         lmd_p4     <= dmem_rdata;
      end
   end

endmodule

// File: tb/tb_mips32_pipe_fwd.sv
module tb_mips32_pipe_fwd;

   localparam logic [5:0] T_ADD   = 6'h00;
   localparam logic [5:0] T_LW    = 6'h08;
   localparam logic [5:0] T_SW    = 6'h09;
   localparam logic [5:0] T_ADDI  = 6'h0A;
   localparam logic [5:0] T_SUBI  = 6'h0B;
   localparam logic [5:0] T_BNEQZ = 6'h0D;
   localparam logic [5:0] T_BEQZ  = 6'h0E;
   localparam logic [31:0] W_HLT  = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_we;
   logic [31:0] dmem_rdata;
   logic        halted;
   logic        illegal_op;
   logic [31:0] retire_cnt;

   logic [31:0] imem [1024];
   logic [31:0] dmem [1024];
   logic        ld_en  = 1'b0;
   logic        ld_clr = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;

   int vectors     = 0;
   int miscompares = 0;
   int we_cnt      = 0;
   int we_base     = 0;

   mips32_pipe_fwd #(
      .XLEN     (32),
      .NREG     (32),
      .IMEM_AW  (10),
      .DMEM_AW  (10),
      .RESET_PC (10'd0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_rdata (dmem_rdata),
      .halted     (halted),
      .illegal_op (illegal_op),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   assign imem_rdata = imem[imem_addr];
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      if (ld_clr) begin
         for (int i = 0; i < 1024; i++) dmem[i] <= '0;
      end else if (ld_en) begin
         dmem[ld_addr] <= ld_data;
      end else if (dmem_we) begin
         dmem[dmem_addr] <= dmem_wdata;
      end
      if (dmem_we) we_cnt <= we_cnt + 1;
   end

   function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic new_test();
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) imem[i] = W_HLT;
      @(posedge clk);
      #1 ld_clr = 1'b1;
      @(posedge clk);
      #1 ld_clr = 1'b0;
   endtask

   task automatic preload(input int a, input logic [31:0] d);
      ld_addr = 10'(a);
      ld_data = d;
      ld_en   = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   task automatic go();
      we_base = we_cnt;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // 1: straight-line ALU with forwarding, HLT in WB during cycle 8
      new_test();
      imem[0] = ri(T_ADDI, 0, 1, 10);
      imem[1] = ri(T_ADDI, 0, 2, 20);
      imem[2] = rr(T_ADD, 1, 2, 3);
      imem[3] = W_HLT;
      check("rst_pc",      32'(imem_addr), 32'd0);
      check("rst_halted",  32'(halted), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
      check("rst_retire",  retire_cnt, 32'd0);
      check("rst_we",      32'(dmem_we), 32'd0);
      go();
      tick(6);  check("t1_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t1_halt_c8",    32'(halted), 32'd1);
      check("t1_illegal", 32'(illegal_op), 32'd0);
      tick(10);
      check("t1_r3",     dut.u_rf.regs[3], 32'd30);
      check("t1_retire", retire_cnt, 32'd4);
      check("t1_pc_frz", 32'(imem_addr), 32'd4);

      // 2: load-use costs exactly one cycle
      new_test();
      preload(0, 32'h55);
      imem[0] = ri(T_LW, 0, 1, 0);
      imem[1] = rr(T_ADD, 1, 1, 2);
      imem[2] = W_HLT;
      go();
      tick(6);  check("t2_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t2_halt_c8",    32'(halted), 32'd1);
      tick(2);
      check("t2_r2",     dut.u_rf.regs[2], 32'hAA);
      check("t2_retire", retire_cnt, 32'd3);

      // 3: countdown loop, two taken branches at 2 bubbles each
      new_test();
      imem[0] = ri(T_ADDI, 0, 1, 3);
      imem[1] = ri(T_SUBI, 1, 1, 1);
      imem[2] = ri(T_BNEQZ, 1, 0, -2);
      imem[3] = W_HLT;
      go();
      tick(14); check("t3_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t3_halt_c16",   32'(halted), 32'd1);
      tick(2);
      check("t3_r1",     dut.u_rf.regs[1], 32'd0);
      check("t3_retire", retire_cnt, 32'd8);

      // 4: stores in the shadow of a taken BEQZ must not write
      new_test();
      preload(5, 32'd7);
      imem[0] = ri(T_ADDI, 0, 2, 9);
      imem[1] = ri(T_BEQZ, 0, 0, 2);
      imem[2] = ri(T_SW, 0, 2, 5);
      imem[3] = ri(T_SW, 0, 2, 5);
      imem[4] = W_HLT;
      go();
      tick(7);  check("t4_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t4_halt_c9",    32'(halted), 32'd1);
      tick(2);
      check("t4_mem5",   dmem[5], 32'd7);
      check("t4_we_cnt", 32'(we_cnt - we_base), 32'd0);
      check("t4_retire", retire_cnt, 32'd3);

      // 5: undefined opcode halts and flags illegal_op
      new_test();
      imem[0] = ri(T_ADDI, 0, 1, 1);
      imem[1] = ri(T_ADDI, 0, 2, 2);
      imem[2] = 32'h8000_0000;
      go();
      tick(5);  check("t5_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t5_halted",     32'(halted), 32'd1);
      check("t5_illegal", 32'(illegal_op), 32'd1);
      tick(2);
      check("t5_retire", retire_cnt, 32'd3);
      check("t5_r2",     dut.u_rf.regs[2], 32'd2);

      // 7: EX/MEM result beats MEM/WB; store data forwarded from MEM
      new_test();
      imem[0] = ri(T_ADDI, 0, 1, 1);
      imem[1] = ri(T_ADDI, 0, 1, 2);
      imem[2] = rr(T_ADD, 1, 1, 2);
      imem[3] = ri(T_SW, 0, 2, 7);
      imem[4] = W_HLT;
      go();
      tick(7);  check("t7_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t7_halt_c9",    32'(halted), 32'd1);
      tick(2);
      check("t7_r2",     dut.u_rf.regs[2], 32'd4);
      check("t7_mem7",   dmem[7], 32'd4);
      check("t7_we_cnt", 32'(we_cnt - we_base), 32'd1);
      check("t7_retire", retire_cnt, 32'd5);

      // 6: reset with LW in WB and SW in EX, then restart from RESET_PC
      new_test();
      preload(0, 32'h55);
      preload(1, 32'h11);
      imem[0] = ri(T_ADDI, 0, 3, 1);
      imem[1] = ri(T_LW, 0, 1, 0);
      imem[2] = ri(T_SW, 0, 1, 1);
      imem[3] = W_HLT;
      go();
      tick(5);
      check("t6_pre_retire", retire_cnt, 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_pc",     32'(imem_addr), 32'd0);
      check("t6_rst_retire", retire_cnt, 32'd0);
      check("t6_rst_we",     32'(dmem_we), 32'd0);
      check("t6_rst_halted", 32'(halted), 32'd0);
      check("t6_rst_r3",     dut.u_rf.regs[3], 32'd0);
      tick(3);
      check("t6_mem1_kept",  dmem[1], 32'h11);
      check("t6_no_store",   32'(we_cnt - we_base), 32'd0);
      check("t6_r1_clear",   dut.u_rf.regs[1], 32'd0);
      go();
      tick(7);  check("t6_halt_early", 32'(halted), 32'd0);
      tick(1);  check("t6_halt_c9",    32'(halted), 32'd1);
      tick(2);
      check("t6_mem1",   dmem[1], 32'h55);
      check("t6_we_cnt", 32'(we_cnt - we_base), 32'd1);
      check("t6_retire", retire_cnt, 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
